// File: rtl/cp0_reg_pkg.sv
// Shared constants for the CP0 register file: register numbers, exception
// encodings and Status/Cause field positions.
package cp0_reg_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;
  localparam logic [4:0] CP0_CONFIG  = 5'd16;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_TR   = 5'h0d;

  localparam logic [31:0] EXCTYPE_INT  = 32'h0000_0001;
  localparam logic [31:0] EXCTYPE_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXCTYPE_RI   = 32'h0000_000a;
  localparam logic [31:0] EXCTYPE_OV   = 32'h0000_000c;
  localparam logic [31:0] EXCTYPE_TR   = 32'h0000_000d;
  localparam logic [31:0] EXCTYPE_ERET = 32'h0000_000e;

  localparam int unsigned STATUS_EXL   = 1;
  localparam int unsigned CAUSE_BD     = 31;
  localparam int unsigned CAUSE_IV     = 23;
  localparam int unsigned CAUSE_WP     = 22;
  localparam int unsigned CAUSE_HWIP_HI = 15;
  localparam int unsigned CAUSE_HWIP_LO = 10;
  localparam int unsigned CAUSE_SWIP_HI = 9;
  localparam int unsigned CAUSE_SWIP_LO = 8;
  localparam int unsigned CAUSE_EXC_HI = 6;
  localparam int unsigned CAUSE_EXC_LO = 2;

  localparam logic [31:0] STATUS_RESET = 32'h1000_0000;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: free-running counter with a sticky match interrupt
// that is cleared by any Compare write.
module cp0_timer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        timer_int_q, timer_int_d;

  always_comb begin
    count_d     = count_we_i ? wdata_i : count_q + 32'd1;
    compare_d   = compare_we_i ? wdata_i : compare_q;
    timer_int_d = timer_int_q;
    // Compare write wins over a same-cycle match so software can always ack.
    if (compare_we_i) begin
      timer_int_d = 1'b0;
    end else if ((compare_q != 32'd0) && (count_q == compare_q)) begin
      timer_int_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q     <= '0;
      compare_q   <= '0;
      timer_int_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      compare_q   <= compare_d;
      timer_int_q <= timer_int_d;
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = timer_int_q;

endmodule

// File: rtl/cp0_reg.sv
// CP0 register file: Status/Cause/EPC with exception entry/return, the
// Count/Compare timer, constant PRId/Config and a combinational MFC0 read port.
module cp0_reg
  import cp0_reg_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE   = 32'h004C_0102,
  parameter logic [31:0] CONFIG_VALUE = 32'h0000_8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  raddr_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        exc_valid;
  logic        exc_eret;
  logic [4:0]  exc_code;

  cp0_timer u_timer (
    .clk_i        (clk),
    .rst_ni       (rst),
    .count_we_i   (we_i && (waddr_i == CP0_COUNT)),
    .compare_we_i (we_i && (waddr_i == CP0_COMPARE)),
    .wdata_i      (data_i),
    .count_o      (count_o),
    .compare_o    (compare_o),
    .timer_int_o  (timer_int_o)
  );

  always_comb begin
    exc_valid = 1'b1;
    exc_eret  = 1'b0;
    exc_code  = EXC_INT;
    case (excepttype_i)
      EXCTYPE_INT:  exc_code = EXC_INT;
      EXCTYPE_SYS:  exc_code = EXC_SYS;
      EXCTYPE_RI:   exc_code = EXC_RI;
      EXCTYPE_TR:   exc_code = EXC_TR;
      EXCTYPE_OV:   exc_code = EXC_OV;
      EXCTYPE_ERET: begin
        exc_valid = 1'b0;
        exc_eret  = 1'b1;
      end
      default:      exc_valid = 1'b0;
    endcase
  end

  // Software write first, then exception fields override it.
  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;

    if (we_i) begin
      case (waddr_i)
        CP0_STATUS: status_d = data_i;
        CP0_CAUSE: begin
          cause_d[CAUSE_SWIP_HI:CAUSE_SWIP_LO] = data_i[CAUSE_SWIP_HI:CAUSE_SWIP_LO];
          cause_d[CAUSE_IV] = data_i[CAUSE_IV];
          cause_d[CAUSE_WP] = data_i[CAUSE_WP];
        end
        CP0_EPC:    epc_d = data_i;
        default:    ;
      endcase
    end

    cause_d[CAUSE_HWIP_HI:CAUSE_HWIP_LO] = int_i;

    if (exc_eret) begin
      status_d[STATUS_EXL] = 1'b0;
    end else if (exc_valid) begin
      // Nested exception keeps the original EPC/BD.
      if (!status_q[STATUS_EXL]) begin
        epc_d = is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
        cause_d[CAUSE_BD] = is_in_delayslot_i;
      end
      status_d[STATUS_EXL] = 1'b1;
      cause_d[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_code;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q <= STATUS_RESET;
      cause_q  <= '0;
      epc_q    <= '0;
    end else begin
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
    end
  end

  always_comb begin
    data_o = '0;
    case (raddr_i)
      CP0_COUNT:   data_o = count_o;
      CP0_COMPARE: data_o = compare_o;
      CP0_STATUS:  data_o = status_q;
      CP0_CAUSE:   data_o = cause_q;
      CP0_EPC:     data_o = epc_q;
      CP0_PRID:    data_o = PRID_VALUE;
      CP0_CONFIG:  data_o = CONFIG_VALUE;
      default:     data_o = '0;
    endcase
  end

  assign status_o = status_q;
  assign cause_o  = cause_q;
  assign epc_o    = epc_q;
  assign prid_o   = PRID_VALUE;
  assign config_o = CONFIG_VALUE;

endmodule

// File: tb/tb_cp0_reg.sv
// Directed bench for cp0_reg: reset, timer, Cause write mask, exception
// entry/return, nested exceptions, write/exception overlap and async reset.
module tb_cp0_reg;

  logic        clk;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] data_i;
  logic [4:0]  raddr_i;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] current_inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] data_o;
  logic [31:0] count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
  logic        timer_int_o;

  int n_checks = 0;
  int n_pass   = 0;

  cp0_reg dut (
    .clk                 (clk),
    .rst                 (rst),
    .we_i                (we_i),
    .waddr_i             (waddr_i),
    .data_i              (data_i),
    .raddr_i             (raddr_i),
    .int_i               (int_i),
    .excepttype_i        (excepttype_i),
    .current_inst_addr_i (current_inst_addr_i),
    .is_in_delayslot_i   (is_in_delayslot_i),
    .data_o              (data_o),
    .count_o             (count_o),
    .compare_o           (compare_o),
    .status_o            (status_o),
    .cause_o             (cause_o),
    .epc_o               (epc_o),
    .config_o            (config_o),
    .prid_o              (prid_o),
    .timer_int_o         (timer_int_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we_i = 1'b0; waddr_i = '0; data_i = '0;
    excepttype_i = '0; current_inst_addr_i = '0; is_in_delayslot_i = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; data_i = d;
    tick();
    we_i = 1'b0;
  endtask

  task automatic exc(input logic [31:0] t, input logic [31:0] pc, input logic ds);
    excepttype_i = t; current_inst_addr_i = pc; is_in_delayslot_i = ds;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    n_checks++;
    if (status_o !== 32'h1000_0000) $display("FAIL reset_status got %h want %h", status_o, 32'h1000_0000);
    else n_pass++;
    n_checks++;
    if ({count_o, compare_o, cause_o, epc_o} !== 128'd0) $display("FAIL reset_zero got %h %h %h %h", count_o, compare_o, cause_o, epc_o);
    else n_pass++;
    n_checks++;
    if (timer_int_o !== 1'b0) $display("FAIL reset_timer got %b want 0", timer_int_o);
    else n_pass++;
    #6 rst = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (count_o !== 32'd5) $display("FAIL count_after_5 got %0d want 5", count_o);
    else n_pass++;
    raddr_i = 5'd15; #1;
    n_checks++;
    if (data_o !== 32'h004C_0102) $display("FAIL read_prid got %h want 004c0102", data_o);
    else n_pass++;
    raddr_i = 5'd16; #1;
    n_checks++;
    if (data_o !== 32'h0000_8000 || config_o !== 32'h0000_8000) $display("FAIL read_config got %h/%h want 00008000", data_o, config_o);
    else n_pass++;
    raddr_i = 5'd3; #1;
    n_checks++;
    if (data_o !== 32'd0) $display("FAIL read_unmapped got %h want 0", data_o);
    else n_pass++;
  endtask

  task automatic test_timer();
    int early;
    repeat (5) tick();
    n_checks++;
    if (count_o !== 32'd10) $display("FAIL count_at_10 got %0d want 10", count_o);
    else n_pass++;
    wr(5'd11, 32'd20);
    early = 0;
    for (int i = 0; i < 9; i++) begin
      if (timer_int_o !== 1'b0) early++;
      tick();
    end
    n_checks++;
    if (count_o !== 32'd20 || timer_int_o !== 1'b0 || early != 0)
      $display("FAIL timer_before_match count %0d int %b early %0d want 20/0/0", count_o, timer_int_o, early);
    else n_pass++;
    tick();
    n_checks++;
    if (timer_int_o !== 1'b1) $display("FAIL timer_rise got %b want 1", timer_int_o);
    else n_pass++;
    repeat (3) tick();
    n_checks++;
    if (timer_int_o !== 1'b1) $display("FAIL timer_hold got %b want 1", timer_int_o);
    else n_pass++;
    wr(5'd11, 32'd50);
    n_checks++;
    if (timer_int_o !== 1'b0 || compare_o !== 32'd50) $display("FAIL timer_clear int %b cmp %0d want 0/50", timer_int_o, compare_o);
    else n_pass++;
    // Compare 0 with count passing through 0 must not fire.
    wr(5'd11, 32'd0);
    wr(5'd9, 32'hFFFF_FFFE);
    n_checks++;
    if (count_o !== 32'hFFFF_FFFE) $display("FAIL count_write got %h want fffffffe", count_o);
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if (count_o !== 32'd0) $display("FAIL count_wrap got %h want 0", count_o);
    else n_pass++;
    repeat (2) tick();
    n_checks++;
    if (timer_int_o !== 1'b0) $display("FAIL compare_zero_fires got %b want 0", timer_int_o);
    else n_pass++;
  endtask

  task automatic test_cause_write();
    int_i = 6'b101010;
    wr(5'd13, 32'hFFFF_FFFF);
    raddr_i = 5'd13; #1;
    n_checks++;
    if (cause_o !== 32'h00C0_AB00 || data_o !== 32'h00C0_AB00) $display("FAIL cause_write got %h/%h want 00c0ab00", cause_o, data_o);
    else n_pass++;
    int_i = 6'b000000;
    tick();
    n_checks++;
    if (cause_o !== 32'h00C0_0300) $display("FAIL cause_int_sample got %h want 00c00300", cause_o);
    else n_pass++;
    wr(5'd13, 32'h0000_0000);
    wr(5'd15, 32'hDEAD_BEEF);
    raddr_i = 5'd15; #1;
    n_checks++;
    if (data_o !== 32'h004C_0102 || prid_o !== 32'h004C_0102) $display("FAIL prid_readonly got %h/%h want 004c0102", data_o, prid_o);
    else n_pass++;
  endtask

  task automatic test_syscall();
    exc(32'h8, 32'h100, 1'b0);
    raddr_i = 5'd14; #1;
    n_checks++;
    if (epc_o !== 32'h100 || data_o !== 32'h100) $display("FAIL sys_epc got %h/%h want 00000100", epc_o, data_o);
    else n_pass++;
    n_checks++;
    if (cause_o[6:2] !== 5'd8 || cause_o[31] !== 1'b0) $display("FAIL sys_cause got %h want exccode 8 bd 0", cause_o);
    else n_pass++;
    n_checks++;
    if (status_o !== 32'h1000_0002) $display("FAIL sys_exl got %h want 10000002", status_o);
    else n_pass++;
    exc(32'he, 32'h500, 1'b1);
    n_checks++;
    if (status_o !== 32'h1000_0000 || epc_o !== 32'h100 || cause_o[6:2] !== 5'd8)
      $display("FAIL eret got st %h epc %h cause %h want 10000000/00000100/exc 8", status_o, epc_o, cause_o);
    else n_pass++;
  endtask

  task automatic test_nested();
    exc(32'hc, 32'h204, 1'b1);
    n_checks++;
    if (epc_o !== 32'h200 || cause_o[31] !== 1'b1 || cause_o[6:2] !== 5'h0c || status_o[1] !== 1'b1)
      $display("FAIL ov_delayslot got epc %h cause %h st %h want 200/bd1 exc 0c/exl1", epc_o, cause_o, status_o);
    else n_pass++;
    exc(32'h8, 32'h300, 1'b0);
    n_checks++;
    if (epc_o !== 32'h200 || cause_o[31] !== 1'b1 || cause_o[6:2] !== 5'h08)
      $display("FAIL nested got epc %h cause %h want 200/bd1 exc 08", epc_o, cause_o);
    else n_pass++;
    exc(32'h5, 32'h400, 1'b0);
    n_checks++;
    if (epc_o !== 32'h200 || cause_o[6:2] !== 5'h08 || status_o !== 32'h1000_0002)
      $display("FAIL unknown_exc got epc %h cause %h st %h want unchanged", epc_o, cause_o, status_o);
    else n_pass++;
    exc(32'he, 32'h0, 1'b0);
  endtask

  task automatic test_write_and_exc();
    we_i = 1'b1; waddr_i = 5'd12; data_i = 32'h0000_FF01;
    excepttype_i = 32'h8; current_inst_addr_i = 32'h0000_0600; is_in_delayslot_i = 1'b0;
    tick();
    idle_inputs();
    n_checks++;
    if (status_o !== 32'h0000_FF03 || epc_o !== 32'h600) $display("FAIL write_plus_exc got st %h epc %h want 0000ff03/00000600", status_o, epc_o);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    excepttype_i = 32'hc; current_inst_addr_i = 32'h0000_0800; is_in_delayslot_i = 1'b1;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (status_o !== 32'h1000_0000 || epc_o !== 32'd0 || cause_o !== 32'd0 || count_o !== 32'd0)
      $display("FAIL async_reset got st %h epc %h cause %h cnt %h want reset values", status_o, epc_o, cause_o, count_o);
    else n_pass++;
    tick();
    n_checks++;
    if (status_o !== 32'h1000_0000 || epc_o !== 32'd0) $display("FAIL reset_hold got st %h epc %h want reset values", status_o, epc_o);
    else n_pass++;
    idle_inputs();
    #3 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    raddr_i = '0;
    int_i = '0;
    idle_inputs();
    #6;
    test_reset();
    test_timer();
    test_cause_write();
    test_syscall();
    test_nested();
    test_write_and_exc();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
